// File: rtl/ytydla_conv_cmac_accu_tree.sv
// Pipelined masked adder tree feeding a first/last-delimited group accumulator.
// The tree has L = ceil(log2(NUM_IN)) registered levels. The accumulator
// register adds one more stage, so the beat-to-result latency is L+1 cycles.
module ytydla_conv_cmac_accu_tree #(
    parameter int NUM_IN    = 25,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         ytydla_core_clk,
    input  logic                         ytydla_core_rst_n,
    input  logic                         in_valid,
    input  logic [NUM_IN*IN_WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]            in_mask,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         cfg_sat_en,
    output logic                         out_valid,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         out_sat
);

    localparam int L      = $clog2(NUM_IN);
    localparam int SUM_W  = IN_WIDTH + L;

    // Elaboration-time parameter checks
    if (NUM_IN < 2 || NUM_IN > 64) begin : g_num_in_chk
        $error("ytydla_conv_cmac_accu_tree: NUM_IN must be in 2..64");
    end
    if (ACC_WIDTH < IN_WIDTH + L) begin : g_acc_width_chk
        $error("ytydla_conv_cmac_accu_tree: ACC_WIDTH must be >= IN_WIDTH + ceil(log2(NUM_IN))");
    end

    // Clamp an (ACC_WIDTH+1)-bit sum into the signed ACC_WIDTH range
    function automatic logic signed [ACC_WIDTH-1:0] sat_clamp(input logic signed [ACC_WIDTH:0] x);
        logic signed [ACC_WIDTH-1:0] max_v;
        logic signed [ACC_WIDTH-1:0] min_v;
        max_v = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        min_v = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        if (x[ACC_WIDTH] != x[ACC_WIDTH-1]) begin
            sat_clamp = x[ACC_WIDTH] ? min_v : max_v;
        end else begin
            sat_clamp = x[ACC_WIDTH-1:0];
        end
    endfunction

    // True when an (ACC_WIDTH+1)-bit sum does not fit in ACC_WIDTH bits
    function automatic logic sat_ovf(input logic signed [ACC_WIDTH:0] x);
        sat_ovf = x[ACC_WIDTH] ^ x[ACC_WIDTH-1];
    endfunction

    // Sideband pipeline: vld_p[k]/first_p[k]/last_p[k] describe tree level k
    logic [L:1] vld_p;
    logic [L:1] first_p;
    logic [L:1] last_p;
    logic [L:0] ld;

    // Level k loads from level k-1 when the beat feeding it is valid
    assign ld = {vld_p, in_valid};

    // Shift valid/first/last alongside the tree levels
    always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
        if (!ytydla_core_rst_n) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
        end else begin
            vld_p[1]   <= in_valid;
            first_p[1] <= in_first;
            last_p[1]  <= in_last;
            for (int k = 2; k <= L; k++) begin
                vld_p[k]   <= vld_p[k-1];
                first_p[k] <= first_p[k-1];
                last_p[k]  <= last_p[k-1];
            end
        end
    end

    // Tree: level 0 is the masked, zero-padded lane vector; level k holds
    // 2^(L-k) exact sums of width IN_WIDTH+k. Pads add zero and fold away.
    genvar gk, gj;
    for (gk = 0; gk <= L; gk++) begin : lvl
        localparam int W = IN_WIDTH + gk;
        localparam int N = 1 << (L - gk);
        logic signed [W-1:0] node [N];

        if (gk == 0) begin : g_lanes
            for (gj = 0; gj < N; gj++) begin : g_lane
                if (gj < NUM_IN) begin : g_real
                    assign node[gj] = in_mask[gj] ? in_data[gj*IN_WIDTH +: IN_WIDTH] : '0;
                end else begin : g_pad
                    assign node[gj] = '0;
                end
            end
        end else begin : g_add
            // Pairwise add of the previous level, loaded only on a valid beat
            always_ff @(posedge ytydla_core_clk) begin
                if (ld[gk-1]) begin
                    for (int j = 0; j < N; j++) begin
                        node[j] <= W'(lvl[gk-1].node[2*j]) + W'(lvl[gk-1].node[2*j+1]);
                    end
                end
            end
        end
    end

    logic signed [SUM_W-1:0] tree_sum;
    assign tree_sum = lvl[L].node[0];

    // Accumulator stage
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        sat;
    logic signed [ACC_WIDTH:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic                        sat_nxt;

    // Next accumulator value: restart on first, otherwise wrap or saturate
    always_comb begin
        acc_sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(tree_sum);
        acc_nxt = acc;
        sat_nxt = sat;
        if (first_p[L]) begin
            acc_nxt = ACC_WIDTH'(tree_sum);
            sat_nxt = 1'b0;
        end else if (cfg_sat_en) begin
            acc_nxt = sat_clamp(acc_sum);
            sat_nxt = sat | sat_ovf(acc_sum);
        end else begin
            acc_nxt = acc_sum[ACC_WIDTH-1:0];
            sat_nxt = sat;
        end
    end

    // Register the accumulator and publish the group result on the last beat
    always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
        if (!ytydla_core_rst_n) begin
            acc       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= vld_p[L] & last_p[L];
            if (vld_p[L]) begin
                acc <= acc_nxt;
                sat <= sat_nxt;
                if (last_p[L]) begin
                    out_data <= acc_nxt;
                    out_sat  <= sat_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ytydla_conv_cmac_accu_tree.sv
// Scoreboard bench for ytydla_conv_cmac_accu_tree: a 32-bit and a 22-bit
// accumulator instance share stimulus; each has its own expectation queue.
module tb_ytydla_conv_cmac_accu_tree;

    localparam int NUM_IN = 25;
    localparam int IN_W   = 16;
    localparam int LAT    = 6;
    localparam logic [NUM_IN-1:0] FULL = '1;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic [NUM_IN-1:0]        in_mask;
    logic                     in_first;
    logic                     in_last;
    logic                     cfg_sat_en;

    logic                     ov32;
    logic signed [31:0]       od32;
    logic                     os32;
    logic                     ov22;
    logic signed [21:0]       od22;
    logic                     os22;

    typedef struct {
        int   data;
        logic sat;
        int   cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q22[$];

    int cyc;
    int tests;
    int fails;

    ytydla_conv_cmac_accu_tree #(.NUM_IN(NUM_IN), .IN_WIDTH(IN_W), .ACC_WIDTH(32)) dut32 (
        .ytydla_core_clk   (clk),
        .ytydla_core_rst_n (rst_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_mask           (in_mask),
        .in_first          (in_first),
        .in_last           (in_last),
        .cfg_sat_en        (cfg_sat_en),
        .out_valid         (ov32),
        .out_data          (od32),
        .out_sat           (os32)
    );

    ytydla_conv_cmac_accu_tree #(.NUM_IN(NUM_IN), .IN_WIDTH(IN_W), .ACC_WIDTH(22)) dut22 (
        .ytydla_core_clk   (clk),
        .ytydla_core_rst_n (rst_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_mask           (in_mask),
        .in_first          (in_first),
        .in_last           (in_last),
        .cfg_sat_en        (cfg_sat_en),
        .out_valid         (ov22),
        .out_data          (od22),
        .out_sat           (os22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever either instance presents a result
    always @(negedge clk) begin
        exp_t e;
        if (ov32) begin
            if (q32.size() == 0) begin
                chk("unexpected_valid32", 1, 0);
            end else begin
                e = q32.pop_front();
                chk("data32", int'(od32), e.data);
                chk("sat32", int'(os32), int'(e.sat));
                chk("cycle32", cyc, e.cyc);
            end
        end
        if (ov22) begin
            if (q22.size() == 0) begin
                chk("unexpected_valid22", 1, 0);
            end else begin
                e = q22.pop_front();
                chk("data22", int'(od22), e.data);
                chk("sat22", int'(os22), int'(e.sat));
                chk("cycle22", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input int val, input logic [NUM_IN-1:0] mask, input logic f, input logic l);
        logic [IN_W-1:0] v16;
        v16 = val[IN_W-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = {NUM_IN{v16}};
        in_mask  = mask;
        in_first = f;
        in_last  = l;
    endtask

    task automatic send(input int val, input logic [NUM_IN-1:0] mask, input logic f, input logic l,
                        input int e32, input logic s32, input int e22, input logic s22);
        exp_t e;
        drive(val, mask, f, l);
        if (l) begin
            e.data = e32; e.sat = s32; e.cyc = cyc + LAT;
            q32.push_back(e);
            e.data = e22; e.sat = s22; e.cyc = cyc + LAT;
            q22.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid32"}, int'(ov32), 0);
        chk({tag, "_data32"}, int'(od32), 0);
        chk({tag, "_sat32"}, int'(os32), 0);
        chk({tag, "_valid22"}, int'(ov22), 0);
        chk({tag, "_data22"}, int'(od22), 0);
        chk({tag, "_sat22"}, int'(os22), 0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mask    = '0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        cfg_sat_en = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic single-beat group of ones
        send(1, FULL, 1'b1, 1'b1, 25, 1'b0, 25, 1'b0);
        idle(8);

        // Masked negative lanes, then full-scale positive lanes
        send(-2, 25'h0FFFFFF, 1'b1, 1'b1, -48, 1'b0, -48, 1'b0);
        send(32767, FULL, 1'b1, 1'b1, 819175, 1'b0, 819175, 1'b0);
        idle(8);

        // Three beats with bubbles in between
        send(100, FULL, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(1);
        send(100, FULL, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(1);
        send(100, FULL, 1'b0, 1'b1, 7500, 1'b0, 7500, 1'b0);
        idle(8);

        // Saturating 3-beat group
        cfg_sat_en = 1'b1;
        idle(1);
        send(32767, FULL, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        send(32767, FULL, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        send(32767, FULL, 1'b0, 1'b1, 2457525, 1'b0, 2097151, 1'b1);
        idle(8);
        // First clears the sticky flag
        send(1, FULL, 1'b1, 1'b1, 25, 1'b0, 25, 1'b0);
        idle(8);

        // Wrapping 3-beat group
        cfg_sat_en = 1'b0;
        idle(1);
        send(32767, FULL, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        send(32767, FULL, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        send(32767, FULL, 1'b0, 1'b1, 2457525, 1'b0, -1736779, 1'b0);
        idle(8);
        send(1, FULL, 1'b1, 1'b1, 25, 1'b0, 25, 1'b0);
        idle(8);

        // Back-to-back single-beat groups
        send(1, FULL, 1'b1, 1'b1, 25, 1'b0, 25, 1'b0);
        send(2, FULL, 1'b1, 1'b1, 50, 1'b0, 50, 1'b0);
        send(3, FULL, 1'b1, 1'b1, 75, 1'b0, 75, 1'b0);
        idle(8);
        chk("held_data32", int'(od32), 75);
        chk("held_data22", int'(od22), 75);

        // Reset mid-group: beats in flight must never produce a result
        drive(100, FULL, 1'b1, 1'b0);
        drive(100, FULL, 1'b0, 1'b0);
        drive(100, FULL, 1'b0, 1'b1);
        idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        send(1, FULL, 1'b1, 1'b1, 25, 1'b0, 25, 1'b0);
        idle(9);

        chk("pending32", q32.size(), 0);
        chk("pending22", q22.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ytydla_conv_cmac_accu_tree.md
# ytydla_conv_cmac_accu_tree

Parametrised, fully pipelined adder tree with a multi-beat accumulator, sitting between the CMAC multiplier array and the CACC partial-sum buffer. It reduces NUM_IN signed lane products per beat into one sum, with per-lane masking from the CMAC sparsity bitmap. It accumulates beat sums across a first/last-delimited group, with selectable saturating or wrapping arithmetic. It accepts one beat per cycle with no backpressure.

## Interface
- NUM_IN, 25, number of input lanes (2..64)
- IN_WIDTH, 16, signed width of each lane product
- ACC_WIDTH, 32, signed accumulator/output width; elaboration error if ACC_WIDTH < IN_WIDTH + L, where L = ceil(log2(NUM_IN))
- ytydla_core_clk  in  1  core clock, all logic on rising edge
- ytydla_core_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid
- in_data  in  NUM_IN*IN_WIDTH  lane i at bits [i*IN_WIDTH +: IN_WIDTH], signed
- in_mask  in  NUM_IN  1 = lane contributes, 0 = lane forced to zero
- in_first  in  1  first beat of an accumulation group (qualified by in_valid)
- in_last  in  1  last beat of a group (qualified by in_valid)
- cfg_sat_en  in  1  1 = saturate accumulator, 0 = two's-complement wrap; quasi-static, change only when idle
- out_valid  out  1  one-cycle pulse, group result available
- out_data  out  ACC_WIDTH  signed group result, held between pulses
- out_sat  out  1  group saturated at least once; valid with out_valid, held between pulses

## Operation
- Masking: lane i = in_mask[i] ? sign-extended in_data lane : 0, applied before the tree.
- Tree: L registered levels. Level k pairs adjacent nodes; an odd node passes through registered. Lanes are zero-padded to 2^L. Level-k node width is IN_WIDTH+k, signed, exact (no overflow).
- Sideband: valid/first/last travel in an L-deep shift register alongside the tree. Data registers load only when the corresponding stage valid is 1.
- Accumulator stage (stage L+1), on a valid beat with sum S:
  - first=1: acc = S (sign-extended), sat flag = 0.
  - first=0: acc = acc + S. With cfg_sat_en=1, the add is done at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; on clamp, the sat flag sets (sticky). With cfg_sat_en=0, the add wraps modulo 2^ACC_WIDTH and the sat flag is unchanged.
  - last=1: out_data = new acc, out_sat = new sat flag, out_valid = 1 for one cycle.
- first and last on the same beat: a single-beat group; out_data = S.
- A beat without first after a completed group continues accumulating on the held acc. This is legal and allows split groups.
- A repeated first mid-group discards the partial acc; there is no error flag.
- Beats with in_valid=0 are bubbles and are ignored anywhere in a group.

## Timing
- Latency: a beat presented at cycle 0 produces its out_valid at cycle L+1. For NUM_IN=25, L=5, latency is 6.
- Throughput: one beat per cycle sustained. Back-to-back groups need no idle cycle.
- Reset (asynchronous assert, synchronous-release assumed upstream): all stage valids = 0, acc = 0, sat flag = 0, out_valid = 0, out_data = 0, out_sat = 0. Beats in flight are dropped, and no out_valid fires for them after release.
- out_data and out_sat change only on an out_valid cycle or on reset.

## Test plan
- Basic: NUM_IN=25, all lanes = 1, mask all ones, one beat with first=last=1 at cycle 0 -> out_valid at cycle 6, out_data=25, out_sat=0.
- Mask/sign: all lanes = -2, mask = 25'h0FFFFFF (lane 24 off), single beat -> out_data = -48. Then lanes = 32767 with full mask -> 819175.
- Multi-beat with bubbles: 3 beats of all lanes = 100, first on beat 0, last on beat 2, one idle cycle between beats -> exactly one out_valid, out_data = 7500, 6 cycles after the last beat.
- Saturation: ACC_WIDTH=22, lanes = 32767, 3-beat group:
  - cfg_sat_en=1 -> out_data = 2097151, out_sat=1.
  - cfg_sat_en=0 -> out_data = -1736779, out_sat=0.
  - A following single-beat group of 1s -> out_sat=0, out_data = 25.
- Back-to-back: groups (first=last) on cycles 0,1,2 with lane values 1,2,3 -> out_valid on cycles 6,7,8 with 25,50,75.
- Reset mid-operation: start a 3-beat group, assert ytydla_core_rst_n=0 at cycle 4 for 2 cycles -> outputs are 0 and no out_valid fires. A fresh single-beat group of 1s then gives 25 at latency 6.
